// File: rtl/pipTypes.sv
// Shared pipeline types: ALU and multiply/divide op codes, plus the memory-stage
// op encoding, byte-enable patterns and access-shape helpers.
package pipTypes;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
    MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
  } muldiv_op_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0, MEM_LB = 4'd1, MEM_LBU = 4'd2, MEM_LH = 4'd3, MEM_LHU = 4'd4,
    MEM_LW = 4'd5, MEM_SB = 4'd6, MEM_SH = 4'd7, MEM_SW = 4'd8
  } mem_op_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_load(mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: is_misaligned = lo[0];
      MEM_LW, MEM_SW:          is_misaligned = (lo != 2'b00);
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(mem_op_t op, logic [1:0] lo);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: byte_enables = BE_BYTE << lo;
      MEM_LH, MEM_LHU, MEM_SH: byte_enables = BE_HALF << lo;
      MEM_LW, MEM_SW:          byte_enables = BE_WORD;
      default:                 byte_enables = 4'b0000;
    endcase
  endfunction

  // Stores drive every lane so the slave can pick whichever lane the enables select.
  function automatic logic [31:0] lane_data(mem_op_t op, logic [31:0] d);
    case (op)
      MEM_SB:  lane_data = {4{d[7:0]}};
      MEM_SH:  lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/ldalign.sv
// Load data aligner: selects the addressed byte/half lane of a read word and
// sign- or zero-extends it to 32 bits.
module ldalign import pipTypes::*; (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_op_t     op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'd0, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memstage.sv
// Memory-access pipeline stage: registers execute results into writeback and runs
// one wait-request data-memory transaction at a time, stalling upstream meanwhile.
module memstage import pipTypes::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  mem_op_t               mem_op,
  input  logic [4:0]            dest_reg,
  input  logic                  dest_reg_valid,
  input  logic                  inval_dest_reg,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_rd,
  output logic                  dmem_wr,
  input  logic                  dmem_waitrequest,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_rdata_valid,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_result,
  output logic [4:0]            wb_dest_reg,
  output logic                  wb_dest_reg_valid,
  output logic                  wb_addr_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  mem_op_t     op_q;
  logic [1:0]  lo_q;
  logic [4:0]  dest_q;
  logic        dest_valid_q;
  logic [31:0] load_q;
  logic [31:0] aligned;
  logic        mem_access;
  logic        misaligned;

  assign mem_access = in_valid && (mem_op != MEM_NONE);
  assign misaligned = mem_access && is_misaligned(mem_op, ex_result[1:0]);
  assign stall      = (state == REQ) || (state == RESP) ||
                      ((state == IDLE) && mem_access && !misaligned);

  ldalign u_ldalign (
    .rdata  (dmem_rdata),
    .addr   (lo_q),
    .op     (op_q),
    .result (aligned)
  );

  // Stage FSM with request and writeback registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      op_q              <= MEM_NONE;
      lo_q              <= 2'b00;
      dest_q            <= 5'd0;
      dest_valid_q      <= 1'b0;
      load_q            <= 32'd0;
      dmem_addr         <= 32'd0;
      dmem_be           <= 4'b0000;
      dmem_wdata        <= 32'd0;
      dmem_rd           <= 1'b0;
      dmem_wr           <= 1'b0;
      wb_valid          <= 1'b0;
      wb_result         <= 32'd0;
      wb_dest_reg       <= 5'd0;
      wb_dest_reg_valid <= 1'b0;
      wb_addr_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_result   <= ex_result;
          wb_dest_reg <= dest_reg;
          if (mem_access && !misaligned) begin
            // Launch the access and leave a bubble in writeback until it completes.
            wb_valid          <= 1'b0;
            wb_dest_reg_valid <= 1'b0;
            wb_addr_err       <= 1'b0;
            dmem_addr         <= {ex_result[31:2], 2'b00};
            dmem_be           <= byte_enables(mem_op, ex_result[1:0]);
            dmem_wdata        <= lane_data(mem_op, store_data);
            dmem_rd           <= is_load(mem_op);
            dmem_wr           <= !is_load(mem_op);
            op_q              <= mem_op;
            lo_q              <= ex_result[1:0];
            dest_q            <= dest_reg;
            dest_valid_q      <= dest_reg_valid && !inval_dest_reg;
            state             <= REQ;
          end else begin
            wb_valid          <= in_valid;
            wb_dest_reg_valid <= dest_reg_valid && !inval_dest_reg && in_valid && !misaligned;
            wb_addr_err       <= misaligned;
          end
        end
        REQ: begin
          if (!dmem_waitrequest) begin
            dmem_rd <= 1'b0;
            dmem_wr <= 1'b0;
            state   <= is_load(op_q) ? RESP : DONE;
          end
        end
        RESP: begin
          if (dmem_rdata_valid) begin
            load_q <= aligned;
            state  <= DONE;
          end
        end
        DONE: begin
          wb_valid          <= 1'b1;
          wb_result         <= is_load(op_q) ? load_q : {dmem_addr[31:2], lo_q};
          wb_dest_reg       <= dest_q;
          wb_dest_reg_valid <= dest_valid_q && is_load(op_q);
          wb_addr_err       <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memstage.sv
// Scoreboard bench for memstage: byte-level memory model, wait-request slave,
// directed cases from the plan, randomized traffic and a mid-transaction reset.
module tb_memstage;
  import pipTypes::*;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] ex_result;
  logic [31:0] store_data;
  mem_op_t     mem_op;
  logic [4:0]  dest_reg;
  logic        dest_reg_valid;
  logic        inval_dest_reg;
  logic        stall;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        dmem_waitrequest;
  logic [31:0] dmem_rdata;
  logic        dmem_rdata_valid;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest_reg;
  logic        wb_dest_reg_valid;
  logic        wb_addr_err;

  memstage #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .ex_result(ex_result),
    .store_data(store_data), .mem_op(mem_op), .dest_reg(dest_reg),
    .dest_reg_valid(dest_reg_valid), .inval_dest_reg(inval_dest_reg), .stall(stall),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_waitrequest(dmem_waitrequest),
    .dmem_rdata(dmem_rdata), .dmem_rdata_valid(dmem_rdata_valid), .wb_valid(wb_valid),
    .wb_result(wb_result), .wb_dest_reg(wb_dest_reg), .wb_dest_reg_valid(wb_dest_reg_valid),
    .wb_addr_err(wb_addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] result;
    logic        chk_result;
    logic [4:0]  dest;
    logic        dest_valid;
    logic        addr_err;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr;
  } bus_exp_t;

  int       checks = 0;
  int       errors = 0;
  wb_exp_t  wbq[$];
  bus_exp_t busq[$];
  logic [7:0]  mbytes [256];
  logic [31:0] smem [64];
  int       sl_wait = 0;
  int       sl_rdelay = 1;
  int       rd_pend = 0;
  int       left = 0;
  bit       in_req = 0;
  bit       noise_en = 0;
  logic [5:0] raddr;
  wb_exp_t  me;
  bus_exp_t sb;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  task automatic set_byte(int a, logic [7:0] v);
    mbytes[a] = v;
    smem[a / 4][8 * (a % 4) +: 8] = v;
  endtask

  // Writeback monitor: every wb_valid cycle must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && wb_valid) begin
      if (wbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got wb_valid 1 expected 0 at %0t", $time);
      end else begin
        me = wbq.pop_front();
        check("wb_dest_reg", {27'd0, wb_dest_reg}, {27'd0, me.dest});
        check("wb_dest_reg_valid", {31'd0, wb_dest_reg_valid}, {31'd0, me.dest_valid});
        check("wb_addr_err", {31'd0, wb_addr_err}, {31'd0, me.addr_err});
        if (me.chk_result) check("wb_result", wb_result, me.result);
      end
    end
  end

  // Wait-request slave backed by a word memory; checks every request cycle.
  initial begin
    dmem_waitrequest = 1'b0;
    dmem_rdata_valid = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      dmem_rdata_valid = 1'b0;
      dmem_rdata = $urandom();
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin
          dmem_rdata_valid = 1'b1;
          dmem_rdata = smem[raddr];
        end
      end else if (dmem_rd || dmem_wr) begin
        if (!in_req) begin
          in_req = 1;
          left = sl_wait;
        end
        if (busq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got request at %h expected none", dmem_addr);
        end else begin
          sb = busq[0];
          check("dmem_addr", dmem_addr, sb.addr);
          check("dmem_be", {28'd0, dmem_be}, {28'd0, sb.be});
          check("dmem_wr", {31'd0, dmem_wr}, {31'd0, sb.wr});
          check("dmem_rd", {31'd0, dmem_rd}, {31'd0, !sb.wr});
          if (sb.wr) check("dmem_wdata", dmem_wdata, sb.wdata);
        end
        if (noise_en && $urandom_range(0, 3) == 0) dmem_rdata_valid = 1'b1;
        if (left > 0) begin
          dmem_waitrequest = 1'b1;
          left--;
        end else begin
          dmem_waitrequest = 1'b0;
          in_req = 0;
          if (busq.size() != 0) void'(busq.pop_front());
          if (dmem_wr) begin
            for (int k = 0; k < 4; k++)
              if (dmem_be[k]) smem[dmem_addr[7:2]][8 * k +: 8] = dmem_wdata[8 * k +: 8];
          end else begin
            rd_pend = sl_rdelay;
            raddr = dmem_addr[7:2];
          end
        end
      end else begin
        dmem_waitrequest = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise_en && $urandom_range(0, 3) == 0) dmem_rdata_valid = 1'b1;
      end
    end
  end

  // Present one instruction (called just after a negedge) and hold it until accepted.
  task automatic issue(mem_op_t op, logic [31:0] addr, logic [31:0] sd, logic [4:0] rd,
                       logic dv, logic inval, logic v, int w, int d);
    int sz, lo, a, exp_edges, edges;
    bit st, mem, ld, mis, sgn;
    longint unsigned val;
    wb_exp_t e;
    bus_exp_t b;
    sl_wait = w; sl_rdelay = d;
    in_valid = v; ex_result = addr; store_data = sd; mem_op = op;
    dest_reg = rd; dest_reg_valid = dv; inval_dest_reg = inval;
    sz = nbytes(op); lo = int'(addr[1:0]); a = int'(addr[7:0]);
    mem = v && (op != MEM_NONE);
    ld  = op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    sgn = op inside {MEM_LB, MEM_LH};
    mis = mem && (lo % sz != 0);
    exp_edges = 1;
    if (v) begin
      e.dest = rd; e.addr_err = mis; e.result = addr; e.chk_result = !mem;
      e.dest_valid = dv && !inval && !mis && (!mem || ld);
      if (mem && !mis) begin
        b.addr = {addr[31:2], 2'b00};
        b.be = 4'(((1 << sz) - 1) << lo);
        b.wr = !ld;
        for (int k = 0; k < 4; k++) b.wdata[8 * k +: 8] = sd[8 * (k % sz) +: 8];
        busq.push_back(b);
        if (ld) begin
          val = 0;
          for (int k = 0; k < sz; k++) val |= longint'(mbytes[a + k]) << (8 * k);
          if (sgn && ((val >> (8 * sz - 1)) & 1) == 1) val |= ~((64'd1 << (8 * sz)) - 1);
          e.result = val[31:0]; e.chk_result = 1;
          exp_edges = 3 + w + d;
        end else begin
          for (int k = 0; k < sz; k++) mbytes[a + k] = sd[8 * k +: 8];
          exp_edges = 3 + w;
        end
      end
      wbq.push_back(e);
    end
    #1;
    edges = 0;
    do begin
      st = stall;
      @(posedge clock);
      #1;
      edges++;
    end while (st && edges < 200);
    check("accept_edges", edges, exp_edges);
    @(negedge clock);
  endtask

  initial begin
    mem_op_t rop;
    logic [31:0] raddr_v;
    reset_n = 1'b0; in_valid = 1'b0; ex_result = 32'd0; store_data = 32'd0;
    mem_op = MEM_NONE; dest_reg = 5'd0; dest_reg_valid = 1'b0; inval_dest_reg = 1'b0;
    for (int i = 0; i < 256; i++) set_byte(i, 8'($urandom()));
    #12;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rd_wr", {30'd0, dmem_rd, dmem_wr}, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wb", {29'd0, wb_valid, wb_dest_reg_valid, wb_addr_err}, 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    issue(MEM_NONE, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b1, 0, 1);
    issue(MEM_SB, 32'h0000_0103, 32'h0000_00AB, 5'd7, 1'b1, 1'b0, 1'b1, 0, 1);
    set_byte(32'h100, 8'h00); set_byte(32'h101, 8'h00);
    set_byte(32'h102, 8'h80); set_byte(32'h103, 8'h00);
    issue(MEM_LB, 32'h0000_0102, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 3, 1);
    issue(MEM_LBU, 32'h0000_0102, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 3, 1);
    issue(MEM_LW, 32'h0000_0202, 32'd0, 5'd10, 1'b1, 1'b0, 1'b1, 0, 1);
    issue(MEM_NONE, 32'h0000_0055, 32'd0, 5'd11, 1'b1, 1'b1, 1'b1, 0, 1);
    set_byte(0, 8'h00); set_byte(1, 8'h00); set_byte(2, 8'hEF); set_byte(3, 8'hBE);
    issue(MEM_LHU, 32'h0000_0002, 32'd0, 5'd12, 1'b1, 1'b0, 1'b1, 0, 1);

    noise_en = 1;
    for (int i = 0; i < 400; i++) begin
      rop = mem_op_t'(4'($urandom_range(0, 8)));
      raddr_v = $urandom();
      if ($urandom_range(0, 1) == 1) raddr_v[1:0] = 2'b00;
      issue(rop, raddr_v, $urandom(), 5'($urandom()), 1'($urandom()), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(1, 3));
    end

    // Reset while a read is outstanding: strobes and stall must drop immediately.
    noise_en = 0;
    sl_wait = 0; sl_rdelay = 3;
    busq.push_back('{addr: 32'h0000_0040, be: 4'b1111, wdata: 32'd0, wr: 1'b0});
    in_valid = 1'b1; ex_result = 32'h0000_0040; mem_op = MEM_LW;
    dest_reg = 5'd3; dest_reg_valid = 1'b1; inval_dest_reg = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0; in_valid = 1'b0; mem_op = MEM_NONE;
    #1;
    check("rst_mid_rd", {31'd0, dmem_rd}, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check("late_rvalid_pending", rd_pend, 0);
    check("wbq_empty", wbq.size(), 0);
    check("busq_empty", busq.size(), 0);
    issue(MEM_NONE, 32'hCAFE_0001, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 0, 1);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("final_wbq_empty", wbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memstage.md
# memstage

Memory-access stage placed directly downstream of the execute stage `ex`. It registers the execute result into the writeback pipeline register. For loads and stores it runs a data-memory transaction over a wait-request bus, aligning and extending load data. It holds the upstream pipeline with `stall` until each access completes.

## Interface
- `DATA_WIDTH`, 32: data and address width (only 32 supported).
- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  execute stage presents an instruction.
- `ex_result`  in  32  execute result; this is the effective address for memory ops.
- `store_data`  in  32  register value to store (rt).
- `mem_op`  in  mem_op_t  MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW.
- `dest_reg`  in  5  destination register.
- `dest_reg_valid`  in  1  instruction writes `dest_reg`.
- `inval_dest_reg`  in  1  MOVZ/MOVN suppression from execute.
- `stall`  out  1  hold execute inputs stable.
- `dmem_addr`  out  32  word address; bits [1:0] are always 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rd` / `dmem_wr`  out  1  request strobes.
- `dmem_waitrequest`  in  1  slave not accepting the request.
- `dmem_rdata`  in  32  read data.
- `dmem_rdata_valid`  in  1  read data valid.
- `wb_valid`  out  1  writeback register holds a real instruction.
- `wb_result`  out  32  value to write.
- `wb_dest_reg`  out  5  destination register.
- `wb_dest_reg_valid`  out  1  write enable, already suppressed by `inval_dest_reg` and by address errors.
- `wb_addr_err`  out  1  misaligned access.

## Operation
- The FSM has four states: IDLE, REQ, RESP and DONE.
- **IDLE, non-memory op or `in_valid`=0:** the `wb_*` registers load the inputs every edge.
  - `wb_result` = `ex_result`.
  - `wb_dest_reg_valid` = `dest_reg_valid & ~inval_dest_reg & in_valid`.
  - `stall`=0.
- **IDLE, misaligned access:** applies to LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - No bus access is made.
  - `wb_addr_err`=1 and `wb_dest_reg_valid`=0, with single-cycle latency.
- **IDLE, aligned memory op:**
  - Capture the address, the lane-replicated data, the byte enables, the op and the destination.
  - Go to REQ. `stall`=1 combinationally in this cycle.
  - `wb_valid` loads 0 (bubble).
- **REQ:** `dmem_rd` or `dmem_wr` is asserted, with stable address, byte enables and data.
  - If `dmem_waitrequest`=0, stores go to DONE and loads go to RESP.
  - Otherwise stay in REQ.
- **RESP:** the strobe is deasserted. On `dmem_rdata_valid`, capture the aligned and extended data and go to DONE.
- **DONE:** `stall`=0 and the `wb_*` registers load the captured result; `wb_valid`=1.
  - Stores set `wb_dest_reg_valid`=0.
  - Next state is IDLE. The next instruction is sampled in IDLE on the following cycle, never in DONE.
- **Byte enables:**
  - Byte ops: `be` = 1<<addr[1:0].
  - Half ops: `be` = 4'b0011 << addr[1:0].
  - Word ops: `be` = 4'b1111.
  - Little-endian lanes.
- **Load extract:** byte = rdata[8*a+7:8*a] and half = rdata[16*a1+15:16*a1], where a = addr[1:0] and a1 = addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- `stall` = (state≠IDLE && state≠DONE) || (state==IDLE && in_valid && aligned memory op).

## Timing
- Reset values: state IDLE, `stall`=0, `dmem_rd`=`dmem_wr`=0, `dmem_be`=0, `dmem_addr`=0, `dmem_wdata`=0, all `wb_*`=0.
- Reset mid-transaction returns the FSM to IDLE asynchronously, and the strobes drop immediately. A read response arriving after reset is ignored.
- Non-memory latency: 1 edge.
- Store, zero wait: 3 edges to `wb_valid` (IDLE→REQ→DONE→IDLE), with `stall` high for 2 cycles.
- Load, zero wait and `rdata_valid` one cycle after accept: 4 edges, with `stall` high for 3 cycles.
- `dmem_rdata_valid` in REQ or IDLE is ignored. Exactly one outstanding request at a time.

## Structure
- `mem_op_t` and the byte-enable constants go in `pipTypes`, alongside `alu_op_t` and `muldiv_op_t`.
- One combinational sub-module, `ldalign`: `rdata`, `addr[1:0]` and op in, extended 32-bit result out. `memstage` holds the FSM, request registers and wb registers.

## Test plan
- ADD result 0x1234 to r5 → next edge: `wb_result`=0x1234, `wb_dest_reg`=5, `wb_dest_reg_valid`=1, `stall`=0 throughout.
- SB addr 0x103, `store_data`=0xAB, zero wait → `dmem_addr`=0x100, `be`=4'b1000, `wdata`=0xABABABAB, `stall` high 2 cycles, `wb_dest_reg_valid`=0.
- LB addr 0x102, `rdata`=0x00800000, `waitrequest` high 3 cycles → `wb_result`=0xFFFFFF80. Repeat with LBU → 0x00000080. `stall` is held through all waits.
- LW addr 0x202 → no `dmem_rd`, `wb_addr_err`=1, `wb_dest_reg_valid`=0, 1-cycle latency.
- MOVZ with `inval_dest_reg`=1 → `wb_dest_reg_valid`=0. A following LHU addr 0x2 with `rdata`=0xBEEF0000 → `wb_result`=0x0000BEEF.
- Assert `reset_n` low during RESP → strobes and `stall` drop at once. A late `rdata_valid` after release produces no `wb_valid`.
